fetch_sequencer: RTL
====================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter START_PC, default 1, word address of the first instruction fetched after start.
REQ-002 Parameter END_PC, default 31, word address of the last instruction fetched; START_PC <= END_PC <= 31.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  begin a program run; sampled in IDLE or DONE only.
REQ-006 halt_req  input  1  abort the current run.
REQ-007 instruction  input  32  word returned combinationally by instruction memory for read_address.
REQ-008 instr_ready  input  1  downstream decode stage accepts instr_out this cycle.
REQ-009 read_address  output  32  word address to instruction memory, zero-extended pc.
REQ-010 instr_out  output  32  registered fetched instruction.
REQ-011 instr_valid  output  1  instr_out holds an unaccepted instruction.
REQ-012 pc  output  5  current program counter.
REQ-013 state  output  2  FSM state: IDLE=0, FETCH=1, ISSUE=2, DONE=3.
REQ-014 done  output  1  high while state==DONE.
REQ-015 issue_count  output  6  number of instructions accepted in the current run.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, FETCH, ISSUE and DONE, with encodings as in REQ-013.
REQ-017 read_address SHALL equal {27'b0, pc} in every state.
REQ-018 IDLE/DONE with start=1 SHALL go to FETCH next edge, load pc=START_PC, and clear issue_count.
REQ-019 start SHALL be ignored in FETCH and ISSUE.
REQ-020 FETCH with instruction != 32'h0 SHALL capture instruction into instr_out and go to ISSUE; latency start-to-first-valid is 2 edges.
REQ-021 FETCH with instruction == 32'h0 SHALL go to DONE with no issue; an all-zero word marks the end of program.
REQ-022 instr_valid SHALL be 1 exactly when state==ISSUE.
REQ-023 instr_out SHALL remain stable while instr_valid=1 and instr_ready=0; the FSM stalls in ISSUE indefinitely.
REQ-024 ISSUE with instr_ready=1 SHALL increment issue_count by 1; if pc==END_PC go to DONE with pc unchanged, else pc<=pc+1 and go to FETCH.
REQ-025 pc SHALL never wrap past 31; END_PC bounds the run.
REQ-026 issue_count SHALL saturate at 63.
REQ-027 halt_req=1 in FETCH SHALL go to DONE next edge with no capture.
REQ-028 halt_req=1 in ISSUE with instr_ready=0 SHALL go to DONE next edge, dropping instr_valid without counting.
REQ-029 halt_req=1 and instr_ready=1 together in ISSUE SHALL complete the handshake (count incremented), then go to DONE regardless of pc.
REQ-030 halt_req SHALL be ignored in IDLE and DONE; if start=1 and halt_req=1 together in IDLE or DONE, start wins.
REQ-031 Accepted instructions per run SHALL be at most END_PC-START_PC+1.

Reset
REQ-032 reset=1 SHALL asynchronously force state=IDLE, pc=START_PC, instr_out=32'h0, issue_count=0, instr_valid=0, done=0.
REQ-033 reset asserted mid-run SHALL abandon any pending instruction immediately; no handshake completes on that edge.
REQ-034 After reset deasserts, the block SHALL stay in IDLE until start.

Verification
REQ-035 Full run: memory words 1..31 non-zero, instr_ready=1 constant, start pulse -> 31 valid beats, instr_out sequence = words 1..31, pc ends 31, DONE, issue_count=31.
REQ-036 Backpressure: instr_ready=0 for 5 cycles on 3rd beat -> instr_out and pc (=3) stable for those cycles, no beat lost or duplicated, final issue_count=31.
REQ-037 Zero terminator: word 4 = 32'h0 -> 3 beats (words 1..3), DONE reached from FETCH with pc=4, issue_count=3.
REQ-038 Halt: halt_req with instr_ready=1 on beat 2 -> issue_count=2, DONE next edge; halt_req with instr_ready=0 -> issue_count=1, instr_valid drops.
REQ-039 Reset mid-run: reset asserted in ISSUE at pc=7 -> outputs at reset values immediately, before the next edge; restart via start -> first instr_out = word 1.
REQ-040 Restart from DONE: start after completed run -> pc=START_PC, issue_count=0, identical beat sequence repeats.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks pc from START_PC to END_PC, fetching words from an
// instruction memory and issuing them to decode with a valid/ready handshake.
module fetch_sequencer #(
  parameter int unsigned START_PC = 1,
  parameter int unsigned END_PC   = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        halt_req,
  input  logic [31:0] instruction,
  input  logic        instr_ready,
  output logic [31:0] read_address,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic [4:0]  pc,
  output logic [1:0]  state,
  output logic        done,
  output logic [5:0]  issue_count
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StIssue = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam logic [4:0] StartPc  = 5'(START_PC);
  localparam logic [4:0] EndPc    = 5'(END_PC);
  localparam logic [5:0] CountMax = 6'd63;

  state_e      state_q, state_d;
  logic [4:0]  pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [5:0]  count_q, count_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= StartPc;
      instr_q <= 32'h0;
      count_q <= 6'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
    unique case (state_q)
      // halt_req is deliberately not looked at here: start always wins
      StIdle, StDone: begin
        if (start) begin
          state_d = StFetch;
          pc_d    = StartPc;
          count_d = 6'd0;
        end
      end
      StFetch: begin
        // An all-zero word terminates the program without being issued
        if (halt_req || (instruction == 32'h0)) begin
          state_d = StDone;
        end else begin
          instr_d = instruction;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (instr_ready) begin
          if (count_q != CountMax) begin
            count_d = count_q + 6'd1;
          end
          // pc holds at END_PC so it can never wrap
          if (halt_req || (pc_q == EndPc)) begin
            state_d = StDone;
          end else begin
            pc_d    = pc_q + 5'd1;
            state_d = StFetch;
          end
        end else if (halt_req) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign read_address = {27'b0, pc_q};
  assign instr_out    = instr_q;
  assign instr_valid  = (state_q == StIssue);
  assign pc           = pc_q;
  assign state        = state_q;
  assign done         = (state_q == StDone);
  assign issue_count  = count_q;

endmodule
